// File: rtl/gpio_pll_pkg.sv
// rtl/gpio_pll_pkg.sv - shared MDRP opcodes, widths and controller state encoding
package gpio_pll_pkg;

  localparam int MDRP_AW = 8;
  localparam int MDRP_DW = 8;

  localparam logic [1:0] MDOPC_NOP     = 2'b00;
  localparam logic [1:0] MDOPC_WRITE   = 2'b01;
  localparam logic [1:0] MDOPC_READ    = 2'b10;
  localparam logic [1:0] MDOPC_SETADDR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETA,
    ST_OP,
    ST_NOPS,
    ST_RDWAIT,
    ST_SETTLE,
    ST_LOCKW,
    ST_DONE
  } mdrp_state_e;

endpackage

// File: rtl/gpio_pll_mdclk_gen.sv
// rtl/gpio_pll_mdclk_gen.sv - free-running MDCLK divider with edge strobes
module gpio_pll_mdclk_gen #(
  parameter int HALF = 4
) (
  input  logic clk,
  input  logic rst,
  output logic mdclk,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int CW = $clog2(HALF);

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick = (cnt == CW'(HALF - 1));

  // Strobes are high in the clk cycle whose closing edge flips mdclk.
  assign rise_evt = tick & ~mdclk;
  assign fall_evt = tick & mdclk;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      mdclk <= 1'b0;
    end else if (tick) begin
      cnt   <= '0;
      mdclk <= ~mdclk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gpio_pll_mdrp_ctrl.sv
// rtl/gpio_pll_mdrp_ctrl.sv - single-request MDRP initiator with optional PLL re-lock wait
module gpio_pll_mdrp_ctrl
  import gpio_pll_pkg::*;
#(
  parameter int MDCLK_HALF   = 4,
  parameter int RD_LAT       = 2,
  parameter int LOCK_SETTLE  = 4,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic               req_wait_lock,
  input  logic [MDRP_AW-1:0] req_addr,
  input  logic [MDRP_DW-1:0] req_wdata,
  output logic               rsp_valid,
  output logic [MDRP_DW-1:0] rsp_rdata,
  output logic               rsp_err,
  input  logic               pll_lock,
  output logic               mdclk,
  output logic [1:0]         mdopc,
  output logic               mdainc,
  output logic [MDRP_DW-1:0] mdwdi,
  input  logic [MDRP_DW-1:0] mdrdo
);

  mdrp_state_e        state, state_nxt;
  logic               rise_evt, fall_evt;
  logic               lat_write, lat_wait;
  logic [MDRP_AW-1:0] lat_addr;
  logic [MDRP_DW-1:0] lat_wdata;
  logic               lock_meta, lock_sync;
  logic [7:0]         edge_cnt;
  logic [15:0]        to_cnt;

  gpio_pll_mdclk_gen #(.HALF(MDCLK_HALF)) u_mdclk_gen (
    .clk      (clk),
    .rst      (rst),
    .mdclk    (mdclk),
    .rise_evt (rise_evt),
    .fall_evt (fall_evt)
  );

  assign req_ready = (state == ST_IDLE) && !rst;
  assign rsp_valid = (state == ST_DONE);
  assign mdainc    = 1'b0;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req_valid) state_nxt = ST_SETA;
      ST_SETA:   if (fall_evt) state_nxt = ST_OP;
      ST_OP:     if (fall_evt) state_nxt = ST_NOPS;
      ST_NOPS: begin
        if (fall_evt) begin
          if (!lat_write)    state_nxt = ST_RDWAIT;
          else if (lat_wait) state_nxt = ST_SETTLE;
          else               state_nxt = ST_DONE;
        end
      end
      // edge_cnt restarts on the fall that drives READ, so the READ-sampling rise is count 0.
      ST_RDWAIT: if (rise_evt && edge_cnt == 8'(RD_LAT)) state_nxt = ST_DONE;
      ST_SETTLE: if (rise_evt && edge_cnt == 8'(LOCK_SETTLE - 1)) state_nxt = ST_LOCKW;
      ST_LOCKW:  if (lock_sync || to_cnt == 16'(LOCK_TIMEOUT - 1)) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mdopc     <= MDOPC_NOP;
      mdwdi     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      lat_write <= 1'b0;
      lat_wait  <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
      edge_cnt  <= '0;
      to_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      lock_meta <= pll_lock;
      lock_sync <= lock_meta;

      if (state == ST_IDLE && req_valid) begin
        lat_write <= req_write;
        lat_wait  <= req_wait_lock;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end

      if (fall_evt && (state == ST_OP || (state == ST_NOPS && lat_write)))
        edge_cnt <= '0;
      else if (rise_evt && edge_cnt != 8'hFF)
        edge_cnt <= edge_cnt + 1'b1;

      if (state != ST_LOCKW)
        to_cnt <= '0;
      else if (to_cnt != 16'hFFFF)
        to_cnt <= to_cnt + 1'b1;

      // Opcodes move only on the falling MDCLK edge so the PLL sees them settled on rise.
      if (fall_evt) begin
        case (state)
          ST_SETA: begin
            mdopc <= MDOPC_SETADDR;
            mdwdi <= lat_addr;
          end
          ST_OP: begin
            mdopc <= lat_write ? MDOPC_WRITE : MDOPC_READ;
            mdwdi <= lat_write ? lat_wdata : '0;
          end
          ST_NOPS: begin
            mdopc <= MDOPC_NOP;
            mdwdi <= '0;
          end
          default: ;
        endcase
      end

      if (state_nxt == ST_DONE && state != ST_DONE) begin
        rsp_rdata <= (state == ST_RDWAIT) ? mdrdo : '0;
        rsp_err   <= (state == ST_LOCKW) && !lock_sync;
      end
    end
  end

endmodule

// File: tb/tb_gpio_pll_mdrp_ctrl.sv
// tb/tb_gpio_pll_mdrp_ctrl.sv - bench with a behavioural PLL MDRP register file and lock source
module tb_gpio_pll_mdrp_ctrl;
  import gpio_pll_pkg::*;

  localparam int MDCLK_HALF   = 4;
  localparam int RD_LAT       = 2;
  localparam int LOCK_SETTLE  = 4;
  localparam int LOCK_TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       rst, req_valid, req_ready, req_write, req_wait_lock;
  logic [7:0] req_addr, req_wdata, rsp_rdata, mdwdi, mdrdo;
  logic       rsp_valid, rsp_err, pll_lock, mdclk, mdainc;
  logic [1:0] mdopc;

  always #5 clk = ~clk;

  gpio_pll_mdrp_ctrl #(
    .MDCLK_HALF(MDCLK_HALF), .RD_LAT(RD_LAT),
    .LOCK_SETTLE(LOCK_SETTLE), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_wait_lock(req_wait_lock), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .pll_lock(pll_lock), .mdclk(mdclk), .mdopc(mdopc),
    .mdainc(mdainc), .mdwdi(mdwdi), .mdrdo(mdrdo)
  );

  int         n_checks = 0, n_fail = 0, cyc = 0;
  logic [7:0] pll_regs [256];
  logic [7:0] exp_regs [256];
  logic [9:0] op_log [$];
  logic       mdclk_q = 1'b0, rst_q = 1'b1;
  logic [1:0] opc_q = 2'b00;
  logic [7:0] wdi_q = 8'h00, m_addr = 8'h00, rd_val = 8'h00;
  int         rd_cnt = 0, wr_rises = 0, lockw_cyc = -1;
  bit         rd_pending = 0, wr_armed = 0;
  int         rsp_cnt = 0, rsp_cyc = 0, acc_cyc = 0;
  logic [7:0] rsp_rd;
  logic       rsp_er;
  int         n0, t, m, busy_hi;
  logic       r_w;
  logic [7:0] r_a, r_d;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  // PLL side: sample ops on MDCLK rise, present read data only on the RD_LAT-th rise after READ.
  task automatic model_step();
    if (rst || rst_q) begin
      rd_pending = 0;
      wr_armed   = 0;
    end else begin
      if (mdopc !== opc_q || mdwdi !== wdi_q)
        chk("op_change_on_fall", {31'b0, mdclk_q && !mdclk}, 1);
      if (mdclk && !mdclk_q) begin
        if (rd_pending) begin
          rd_cnt++;
          mdrdo = (rd_cnt == RD_LAT - 1) ? rd_val : ~rd_val;
          if (rd_cnt >= RD_LAT) rd_pending = 0;
        end
        if (wr_armed) begin
          wr_rises++;
          if (wr_rises == LOCK_SETTLE) begin
            lockw_cyc = cyc;
            wr_armed  = 0;
          end
        end
        case (mdopc)
          MDOPC_SETADDR: m_addr = mdwdi;
          MDOPC_WRITE: begin
            pll_regs[m_addr] = mdwdi;
            wr_armed = 1;
            wr_rises = 0;
          end
          MDOPC_READ: begin
            rd_pending = 1;
            rd_cnt = 0;
            rd_val = pll_regs[m_addr];
            mdrdo  = ~rd_val;
          end
          default: ;
        endcase
        if (mdopc != MDOPC_NOP) op_log.push_back({mdopc, mdwdi});
      end
      if (rsp_valid) begin
        rsp_cnt++;
        rsp_cyc = cyc;
        rsp_rd  = rsp_rdata;
        rsp_er  = rsp_err;
      end
    end
    mdclk_q = mdclk;
    opc_q   = mdopc;
    wdi_q   = mdwdi;
    rst_q   = rst;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    model_step();
  endtask

  task automatic issue(input logic w, input logic wl, input logic [7:0] a, input logic [7:0] d);
    int k;
    k = 0;
    while (req_ready !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    chk("ready_before_issue", req_ready, 1);
    op_log.delete();
    lockw_cyc = -1;
    wr_armed  = 0;
    req_valid = 1; req_write = w; req_wait_lock = wl; req_addr = a; req_wdata = d;
    tick();
    acc_cyc   = cyc;
    req_valid = 0; req_addr = 8'($urandom); req_wdata = 8'($urandom);
  endtask

  task automatic wait_rsp(input int budget);
    int base, k;
    base = rsp_cnt;
    k = 0;
    while (rsp_cnt == base && k < budget) begin
      tick();
      k++;
    end
    chk("rsp_arrived", rsp_cnt - base, 1);
  endtask

  task automatic txn(input logic w, input logic [7:0] a, input logic [7:0] d);
    issue(w, 1'b0, a, d);
    wait_rsp(200);
    chk("rsp_err", rsp_er, 0);
    chk("op_count", op_log.size(), 2);
    chk("op_setaddr", op_log[0], {MDOPC_SETADDR, a});
    if (w) begin
      exp_regs[a] = d;
      chk("op_write", op_log[1], {MDOPC_WRITE, d});
      chk("wr_rdata_zero", rsp_rd, 0);
    end else begin
      chk("op_read", op_log[1], {MDOPC_READ, 8'h00});
      chk("rd_data", rsp_rd, exp_regs[a]);
    end
  endtask

  initial begin
    rst = 1; req_valid = 0; req_write = 0; req_wait_lock = 0;
    req_addr = 0; req_wdata = 0; pll_lock = 1; mdrdo = 0;
    for (int i = 0; i < 256; i++) begin
      pll_regs[i] = 8'($urandom);
      exp_regs[i] = pll_regs[i];
    end
    repeat (3) tick();
    chk("rst_mdclk", mdclk, 0);
    chk("rst_mdopc", mdopc, 0);
    chk("rst_mdainc", mdainc, 0);
    chk("rst_mdwdi", mdwdi, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    rst = 0;
    tick();
    chk("ready_after_rst", req_ready, 1);

    txn(1'b1, 8'h1C, 8'h5A);
    chk("wr_latency", {31'b0, (rsp_cyc - acc_cyc) <= 4 * 2 * MDCLK_HALF}, 1);
    txn(1'b0, 8'h1C, 8'h00);
    chk("rd_1c", rsp_rd, 8'h5A);
    repeat (5) tick();
    chk("rdata_hold", rsp_rdata, 8'h5A);

    for (int k = 0; k < 20; k++) begin
      r_w = 1'($urandom);
      r_a = 8'h80 + 8'($urandom_range(0, 3));
      r_d = 8'($urandom);
      txn(r_w, r_a, r_d);
      repeat ($urandom_range(0, 5)) tick();
    end

    // lock drops, comes back 100 clk after the request
    pll_lock = 0;
    issue(1'b1, 1'b1, 8'h21, 8'hC3);
    exp_regs[8'h21] = 8'hC3;
    n0 = rsp_cnt;
    repeat (100) tick();
    chk("no_rsp_while_unlocked", rsp_cnt, n0);
    chk("lockw_reached", {31'b0, lockw_cyc > acc_cyc}, 1);
    pll_lock = 1;
    m = cyc;
    wait_rsp(20);
    chk("relock_delay", rsp_cyc - m, 3);
    chk("relock_err", rsp_er, 0);

    // lock never returns
    pll_lock = 0;
    issue(1'b1, 1'b1, 8'h22, 8'h3C);
    exp_regs[8'h22] = 8'h3C;
    wait_rsp(600);
    chk("timeout_err", rsp_er, 1);
    chk("timeout_delay", rsp_cyc - lockw_cyc, LOCK_TIMEOUT);
    chk("timeout_rdata", rsp_rd, 0);
    pll_lock = 1;
    repeat (4) tick();

    // lock already high when waiting starts
    issue(1'b1, 1'b1, 8'h23, 8'h99);
    exp_regs[8'h23] = 8'h99;
    wait_rsp(200);
    chk("lock_high_delay", rsp_cyc - lockw_cyc, 1);
    chk("lock_high_err", rsp_er, 0);

    // request held valid with changing fields while busy
    t = 0;
    while (req_ready !== 1'b1 && t < 100) begin
      tick();
      t++;
    end
    op_log.delete();
    n0 = rsp_cnt;
    busy_hi = 0;
    req_valid = 1; req_write = 1; req_wait_lock = 0; req_addr = 8'h40; req_wdata = 8'h11;
    tick();
    t = 0;
    while (rsp_cnt == n0 && t < 200) begin
      if (req_ready) busy_hi++;
      req_addr = 8'($urandom); req_wdata = 8'($urandom);
      tick();
      t++;
    end
    chk("busy_rsp", rsp_cnt - n0, 1);
    chk("ready_in_done", req_ready, 0);
    req_valid = 0;
    exp_regs[8'h40] = 8'h11;
    chk("busy_ready_low", busy_hi, 0);
    chk("busy_op_count", op_log.size(), 2);
    chk("busy_setaddr", op_log[0], {MDOPC_SETADDR, 8'h40});
    chk("busy_write", op_log[1], {MDOPC_WRITE, 8'h11});
    tick();
    chk("ready_after_done", req_ready, 1);
    chk("rsp_one_cycle", rsp_valid, 0);

    // reset while the address phase is on the bus
    issue(1'b1, 1'b0, 8'h33, 8'h77);
    t = 0;
    while (mdopc !== MDOPC_SETADDR && t < 50) begin
      tick();
      t++;
    end
    chk("reach_setaddr", mdopc, MDOPC_SETADDR);
    n0 = rsp_cnt;
    rst = 1;
    tick();
    chk("abort_mdopc", mdopc, MDOPC_NOP);
    chk("abort_ready", req_ready, 0);
    tick();
    rst = 0;
    repeat (60) tick();
    chk("abort_no_rsp", rsp_cnt, n0);
    txn(1'b0, 8'h33, 8'h00);
    txn(1'b1, 8'h33, 8'h78);
    txn(1'b0, 8'h33, 8'h00);
    txn(1'b0, 8'h21, 8'h00);
    txn(1'b0, 8'h22, 8'h00);
    chk("mdainc_const", mdainc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
